// File: rtl/instr_fetch_unit.sv
// Multi-beat instruction fetch unit: owns the PC, reads INSTR_W/DATA_W
// narrow memory beats over a req/valid handshake and assembles them
// little-endian into the instruction register.
module instr_fetch_unit #(
  parameter int                DATA_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_valid,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy
);

  localparam int BEATS = INSTR_W / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t              state, state_n;
  logic [BW-1:0]       beat, beat_n;
  logic [INSTR_W-1:0]  sbuf, sbuf_n;
  logic [INSTR_W-1:0]  merged;
  logic [ADDR_W-1:0]   pc_n;
  logic [INSTR_W-1:0]  instr_n;
  logic                valid_n;

  // State register: all fetch state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      beat        <= '0;
      sbuf        <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      beat        <= beat_n;
      sbuf        <= sbuf_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
    end
  end

  // Next-state logic: start/redirect in IDLE, beat capture or abort in FETCH
  always_comb begin
    state_n = state;
    pc_n    = pc;
    beat_n  = beat;
    sbuf_n  = sbuf;
    instr_n = instr;
    valid_n = 1'b0;
    // Shadow buffer with the current beat patched in; on the last beat this
    // is the completed instruction {mem_rdata, lower beats}.
    merged  = sbuf;
    merged[int'(beat)*DATA_W +: DATA_W] = mem_rdata;
    case (state)
      IDLE: begin
        if (pc_load) pc_n = pc_next;
        if (start) begin
          state_n = FETCH;
          beat_n  = '0;
        end
      end
      FETCH: begin
        if (pc_load) begin
          // Redirect wins over any data returned in the same cycle
          pc_n    = pc_next;
          state_n = IDLE;
          beat_n  = '0;
        end else if (mem_valid) begin
          sbuf_n = merged;
          if (beat == LAST_BEAT) begin
            instr_n = merged;
            valid_n = 1'b1;
            pc_n    = pc + ADDR_W'(BEATS);
            beat_n  = '0;
            state_n = IDLE;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_req  = (state == FETCH);
  assign busy     = (state == FETCH);
  assign mem_addr = pc + ADDR_W'(beat);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: 8-bit beat instance (4 beats)
// and a 16-bit beat instance (2 beats) against a memory-image reference.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 8-bit data instance
  logic        start, pc_load, mem_valid;
  logic [7:0]  pc_next, mem_rdata;
  logic        mem_req, instr_valid, busy;
  logic [7:0]  mem_addr, pc;
  logic [31:0] instr;

  // 16-bit data instance
  logic        w_start, w_pc_load, w_mem_valid;
  logic [7:0]  w_pc_next;
  logic [15:0] w_mem_rdata;
  logic        w_mem_req, w_instr_valid, w_busy;
  logic [7:0]  w_mem_addr, w_pc;
  logic [31:0] w_instr;

  instr_fetch_unit #(.DATA_W(8), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load), .pc_next(pc_next),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .busy(busy)
  );

  instr_fetch_unit #(.DATA_W(16), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h10)) dut16 (
    .clk(clk), .reset(reset), .start(w_start), .pc_load(w_pc_load), .pc_next(w_pc_next),
    .mem_rdata(w_mem_rdata), .mem_valid(w_mem_valid), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .pc(w_pc), .instr(w_instr), .instr_valid(w_instr_valid), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem8  [256];
  logic [15:0] mem16 [256];

  // Reference state: architectural PC and last completed instruction
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  w_m_pc;
  logic [31:0] w_m_instr;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch on the 8-bit instance. waits[k*8+:8] = wait cycles before beat k.
  task automatic fetch8(input logic [31:0] waits, input bit load, input logic [7:0] npc);
    logic [7:0]  base, a;
    logic [31:0] exp;
    int nw;
    base = load ? npc : m_pc;
    for (int k = 0; k < 4; k++) begin
      a = base + 8'(k);
      exp[k*8 +: 8] = mem8[a];
    end
    start = 1'b1; pc_load = load; pc_next = npc;
    cycle();
    pc_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a  = base + 8'(k);
      nw = int'(waits[k*8 +: 8]);
      for (int w = 0; w < nw; w++) begin
        start = 1'(($urandom_range(0, 1)));
        checks++; if (mem_addr !== a) begin errors++; $display("FAIL wait_addr: got %h want %h", mem_addr, a); end
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wait_req: req=%b busy=%b want 1", mem_req, busy); end
        checks++; if (instr !== m_instr) begin errors++; $display("FAIL wait_instr_hold: got %h want %h", instr, m_instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b want 0", instr_valid); end
        mem_valid = 1'b0; mem_rdata = 8'($urandom);
        cycle();
      end
      start = 1'(($urandom_range(0, 1)));
      checks++; if (mem_addr !== a) begin errors++; $display("FAIL beat_addr: beat %0d got %h want %h", k, mem_addr, a); end
      checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL beat_req: req=%b valid=%b want 1/0", mem_req, instr_valid); end
      mem_valid = 1'b1; mem_rdata = mem8[a];
      cycle();
      mem_valid = 1'b0;
    end
    start = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL done_valid: got %b want 1", instr_valid); end
    checks++; if (instr !== exp) begin errors++; $display("FAIL done_instr: got %h want %h", instr, exp); end
    checks++; if (pc !== 8'(base + 8'd4)) begin errors++; $display("FAIL done_pc: got %h want %h", pc, 8'(base + 8'd4)); end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL done_busy: busy=%b req=%b want 0", busy, mem_req); end
    m_instr = exp;
    m_pc    = base + 8'd4;
  endtask

  // One fetch on the 16-bit instance (two beats, PC step 2)
  task automatic fetch16(input int w0, input int w1, input bit load, input logic [7:0] npc);
    logic [7:0]  base, a;
    logic [31:0] exp;
    int nw;
    base = load ? npc : w_m_pc;
    a = base + 8'd1;
    exp = {mem16[a], mem16[base]};
    w_start = 1'b1; w_pc_load = load; w_pc_next = npc;
    cycle();
    w_start = 1'b0; w_pc_load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a  = base + 8'(k);
      nw = (k == 0) ? w0 : w1;
      for (int w = 0; w < nw; w++) begin
        checks++; if (w_mem_addr !== a || w_mem_req !== 1'b1) begin errors++; $display("FAIL w16_wait: addr %h req %b want %h/1", w_mem_addr, w_mem_req, a); end
        w_mem_valid = 1'b0;
        cycle();
      end
      checks++; if (w_mem_addr !== a || w_instr_valid !== 1'b0) begin errors++; $display("FAIL w16_beat: addr %h valid %b want %h/0", w_mem_addr, w_instr_valid, a); end
      w_mem_valid = 1'b1; w_mem_rdata = mem16[a];
      cycle();
      w_mem_valid = 1'b0;
    end
    checks++; if (w_instr_valid !== 1'b1 || w_instr !== exp) begin errors++; $display("FAIL w16_done: valid %b instr %h want 1/%h", w_instr_valid, w_instr, exp); end
    checks++; if (w_pc !== 8'(base + 8'd2) || w_busy !== 1'b0) begin errors++; $display("FAIL w16_pc: pc %h busy %b want %h/0", w_pc, w_busy, 8'(base + 8'd2)); end
    w_m_instr = exp;
    w_m_pc    = base + 8'd2;
  endtask

  task automatic idle_check();
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_flags: valid %b busy %b req %b want 0", instr_valid, busy, mem_req); end
    checks++; if (pc !== m_pc || instr !== m_instr) begin errors++; $display("FAIL idle_state: pc %h instr %h want %h/%h", pc, instr, m_pc, m_instr); end
  endtask

  task automatic idle_load(input logic [7:0] npc);
    pc_load = 1'b1; pc_next = npc;
    cycle();
    pc_load = 1'b0;
    m_pc = npc;
    idle_check();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 0; pc_load = 0; pc_next = 0; mem_valid = 0; mem_rdata = 0;
    w_start = 0; w_pc_load = 0; w_pc_next = 0; w_mem_valid = 0; w_mem_rdata = 0;
    #1;
    m_pc = 8'h00; m_instr = '0; w_m_pc = 8'h10; w_m_instr = '0;
    @(negedge clk);
    reset = 1'b0;
    idle_check();
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    checks++; if (w_pc !== 8'h10 || w_mem_addr !== 8'h10 || w_instr !== '0) begin errors++; $display("FAIL reset_w16: pc %h addr %h instr %h want 10/10/0", w_pc, w_mem_addr, w_instr); end
    cycle();
    idle_check();
  endtask

  task automatic test_basic();
    mem8[0] = 8'h20; mem8[1] = 8'h20; mem8[2] = 8'h85; mem8[3] = 8'h00;
    fetch8(32'h0, 1'b0, 8'h00);
    checks++; if (instr !== 32'h00852020) begin errors++; $display("FAIL basic_instr: got %h want 00852020", instr); end
    cycle();
    idle_check();
  endtask

  task automatic test_wait_states();
    fetch8(32'h0, 1'b0, 8'h00);   // loads a different instr from 4..7
    cycle();
    idle_load(8'h00);
    fetch8(32'h02000200, 1'b0, 8'h00);
    checks++; if (instr !== 32'h00852020) begin errors++; $display("FAIL wait_instr: got %h want 00852020", instr); end
    cycle();
    idle_check();
  endtask

  task automatic test_wrap();
    idle_load(8'hFE);
    fetch8(32'h0, 1'b0, 8'h00);
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL wrap_pc: got %h want 02", pc); end
    cycle();
  endtask

  task automatic test_abort();
    logic [7:0] base;
    base = m_pc;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_valid = 1'b1; mem_rdata = mem8[8'(base + 8'(k))];
      cycle();
    end
    checks++; if (mem_addr !== 8'(base + 8'd2)) begin errors++; $display("FAIL abort_addr: got %h want %h", mem_addr, 8'(base + 8'd2)); end
    pc_load = 1'b1; pc_next = 8'h40; mem_valid = 1'b1; mem_rdata = 8'hAA;
    cycle();
    pc_load = 1'b0; mem_valid = 1'b0;
    m_pc = 8'h40;
    idle_check();
    cycle();
    idle_check();
    fetch8(32'h0, 1'b0, 8'h00);
    cycle();
  endtask

  task automatic test_back_to_back();
    fetch8(32'h0, 1'b0, 8'h00);
    fetch8(32'h00010000, 1'b0, 8'h00);   // start issued in the instr_valid cycle
    cycle();
    idle_check();
    fetch8(32'h0, 1'b1, 8'h10);          // simultaneous start + pc_load
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] waits;
    for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
    for (int it = 0; it < 30; it++) begin
      waits = '0;
      for (int k = 0; k < 4; k++) waits[k*8 +: 8] = 8'($urandom_range(0, 2));
      fetch8(waits, ($urandom_range(0, 3) == 0), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        cycle();
        idle_check();
      end
    end
    cycle();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    mem_valid = 1'b1; mem_rdata = 8'h5A;
    cycle();
    mem_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset: req %b busy %b want 1", mem_req, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL async_flags: req %b busy %b valid %b want 0", mem_req, busy, instr_valid); end
    checks++; if (pc !== 8'h00 || instr !== '0 || mem_addr !== 8'h00) begin errors++; $display("FAIL async_state: pc %h instr %h addr %h want 0", pc, instr, mem_addr); end
    checks++; if (w_pc !== 8'h10 || w_instr !== '0) begin errors++; $display("FAIL async_w16: pc %h instr %h want 10/0", w_pc, w_instr); end
    @(negedge clk);
    reset = 1'b0;
    m_pc = 8'h00; m_instr = '0; w_m_pc = 8'h10; w_m_instr = '0;
    idle_check();
  endtask

  task automatic test_wide();
    for (int i = 0; i < 256; i++) mem16[i] = 16'($urandom);
    fetch16(0, 0, 1'b0, 8'h00);
    checks++; if (w_pc !== 8'h12) begin errors++; $display("FAIL w16_step: got %h want 12", w_pc); end
    fetch16(1, 2, 1'b1, 8'hFF);
    checks++; if (w_pc !== 8'h01) begin errors++; $display("FAIL w16_wrap: got %h want 01", w_pc); end
    for (int it = 0; it < 10; it++) begin
      fetch16($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 2) == 0), 8'($urandom));
      cycle();
      checks++; if (w_instr_valid !== 1'b0 || w_instr !== w_m_instr) begin errors++; $display("FAIL w16_idle: valid %b instr %h want 0/%h", w_instr_valid, w_instr, w_m_instr); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem8[i]  = 8'($urandom);
      mem16[i] = 16'($urandom);
    end
    test_reset();
    test_basic();
    test_wait_states();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
